sram8t_ctrl: RTL and testbench

Request/response front-end that sits directly upstream of the sram8t macro and drives its cs/we/re/addr/din pins.
- Accepts single-word read/write requests over a valid/ready handshake.
- Sequences the one-cycle SRAM strobes and waits the macro's read latency.
- Returns read data over a second valid/ready channel with backpressure.
- Optional power-on scrub zero-fills the array before the first request.

---
 rtl/sram8t_ctrl.sv | 163 ++++++++++++++++
 tb/tb_sram8t_ctrl.sv | 368 ++++++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/sram8t_ctrl.sv
`default_nettype none
// ============================================================================
//  Module   : sram8t_ctrl
//  Purpose  : Request/response front-end that sequences the sram8t macro pins.
//             Optional power-on scrub enabled by macro SRAM8T_CTRL_INIT_EN.
//  Revision : 1.0 - initial release
// ============================================================================
module sram8t_ctrl #(
    parameter int ADDR_WIDTH = 4,
    parameter int DATA_WIDTH = 8,
    parameter int RD_LAT     = 1
`ifdef SRAM8T_CTRL_INIT_EN
   ,parameter logic [DATA_WIDTH-1:0] INIT_VALUE = '0
`endif
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic                  req_valid,
    output logic                  req_ready,
    input  logic                  req_we,
    input  logic [ADDR_WIDTH-1:0] req_addr,
    input  logic [DATA_WIDTH-1:0] req_wdata,
    output logic                  rsp_valid,
    input  logic                  rsp_ready,
    output logic [DATA_WIDTH-1:0] rsp_rdata,
    output logic                  busy,
    output logic                  sram_cs,
    output logic                  sram_we,
    output logic                  sram_re,
    output logic [ADDR_WIDTH-1:0] sram_addr,
    output logic [DATA_WIDTH-1:0] sram_din,
    input  logic [DATA_WIDTH-1:0] sram_dout
);

    typedef enum logic [2:0] {
        S_IDLE  = 3'd0,
        S_WRITE = 3'd1,
        S_READ  = 3'd2,
        S_WAIT  = 3'd3,
        S_RESP  = 3'd4,
        S_INIT  = 3'd5
    } state_t;

    localparam logic [2:0] c_RD_LAT = 3'(RD_LAT);

    state_t                r_state;
    logic [2:0]            r_wait_cnt;
    logic                  r_cs;
    logic                  r_we;
    logic                  r_re;
    logic [ADDR_WIDTH-1:0] r_addr;
    logic [DATA_WIDTH-1:0] r_din;
    logic                  r_rsp_valid;
    logic [DATA_WIDTH-1:0] r_rdata;
    logic                  w_accept;

`ifdef SRAM8T_CTRL_INIT_EN
    logic [ADDR_WIDTH-1:0] r_init_addr;
    logic                  w_init_active;
`endif

    assign req_ready = (r_state == S_IDLE) && !rst;
    assign busy      = (r_state != S_IDLE) && !rst;
    assign w_accept  = req_valid && req_ready;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
`ifdef SRAM8T_CTRL_INIT_EN
            r_state     <= S_INIT;
            r_init_addr <= '0;
`else
            r_state     <= S_IDLE;
`endif
            r_wait_cnt  <= 3'd0;
            r_cs        <= 1'b0;
            r_we        <= 1'b0;
            r_re        <= 1'b0;
            r_addr      <= '0;
            r_din       <= '0;
            r_rsp_valid <= 1'b0;
            r_rdata     <= '0;
        end else begin
            case (r_state)
                S_IDLE: begin
                    // The pin registers double as the captured request.
                    if (w_accept) begin
                        r_cs   <= 1'b1;
                        r_addr <= req_addr;
                        if (req_we) begin
                            r_we    <= 1'b1;
                            r_din   <= req_wdata;
                            r_state <= S_WRITE;
                        end else begin
                            r_re    <= 1'b1;
                            r_state <= S_READ;
                        end
                    end
                end
                S_WRITE: begin
                    r_cs    <= 1'b0;
                    r_we    <= 1'b0;
                    r_state <= S_IDLE;
                end
                S_READ: begin
                    r_cs       <= 1'b0;
                    r_re       <= 1'b0;
                    r_wait_cnt <= c_RD_LAT;
                    r_state    <= S_WAIT;
                end
                S_WAIT: begin
                    r_wait_cnt <= r_wait_cnt - 3'd1;
                    if (r_wait_cnt == 3'd1) begin
                        r_rdata     <= sram_dout;
                        r_rsp_valid <= 1'b1;
                        r_state     <= S_RESP;
                    end
                end
                S_RESP: begin
                    if (rsp_ready) begin
                        r_rsp_valid <= 1'b0;
                        r_state     <= S_IDLE;
                    end
                end
`ifdef SRAM8T_CTRL_INIT_EN
                S_INIT: begin
                    // Track the scrub address so the pins hold it after exit.
                    r_addr      <= r_init_addr;
                    r_din       <= INIT_VALUE;
                    r_init_addr <= r_init_addr + ADDR_WIDTH'(1);
                    if (&r_init_addr) begin
                        r_state <= S_IDLE;
                    end
                end
`endif
                default: begin
                    r_cs    <= 1'b0;
                    r_we    <= 1'b0;
                    r_re    <= 1'b0;
                    r_state <= S_IDLE;
                end
            endcase
        end
    end

`ifdef SRAM8T_CTRL_INIT_EN
    // Scrub strobes come straight from the state so the first cycle after reset writes.
    assign w_init_active = (r_state == S_INIT) && !rst;
    assign sram_cs   = r_cs | w_init_active;
    assign sram_we   = r_we | w_init_active;
    assign sram_addr = w_init_active ? r_init_addr : r_addr;
    assign sram_din  = w_init_active ? INIT_VALUE  : r_din;
`else
    assign sram_cs   = r_cs;
    assign sram_we   = r_we;
    assign sram_addr = r_addr;
    assign sram_din  = r_din;
`endif
    assign sram_re   = r_re;
    assign rsp_valid = r_rsp_valid;
    assign rsp_rdata = r_rdata;

endmodule
`default_nettype wire

// File: tb/tb_sram8t_ctrl.sv
`default_nettype none
// ============================================================================
//  Module   : tb_sram8t_ctrl
//  Purpose  : Scoreboard bench for sram8t_ctrl with RD_LAT=1 and RD_LAT=3 SRAM models.
//  Revision : 1.0 - initial release
// ============================================================================
module tb_sram8t_ctrl;

    logic       clk = 1'b0;
    logic       rst = 1'b1;

    logic       req_valid = 1'b0, req_ready, req_we = 1'b0;
    logic [3:0] req_addr = 4'h0;
    logic [7:0] req_wdata = 8'h00;
    logic       rsp_valid, rsp_ready = 1'b1;
    logic [7:0] rsp_rdata;
    logic       busy, sram_cs, sram_we, sram_re;
    logic [3:0] sram_addr;
    logic [7:0] sram_din, sram_dout;

    logic       req_valid3 = 1'b0, req_ready3, req_we3 = 1'b0;
    logic [3:0] req_addr3 = 4'h0;
    logic [7:0] req_wdata3 = 8'h00;
    logic       rsp_valid3, rsp_ready3 = 1'b1;
    logic [7:0] rsp_rdata3;
    logic       busy3, sram_cs3, sram_we3, sram_re3;
    logic [3:0] sram_addr3;
    logic [7:0] sram_din3, sram_dout3;

    logic [7:0] mem1 [16];
    logic [7:0] mem3 [16];
    logic [7:0] p0 = 8'hEE, p1 = 8'hEE, p2 = 8'hEE;
    logic [7:0] exp_mem [16];
    logic [7:0] exp_q [$];
    logic [7:0] last_rd;

    int n_checks = 0, n_fail = 0;
    int cyc = 0, acc_cyc = 0;
    int wr_strobes = 0, cs_strobes = 0, conflicts = 0;

    always #5 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;

    sram8t_ctrl #(.ADDR_WIDTH(4), .DATA_WIDTH(8), .RD_LAT(1)) dut (
        .clk(clk), .rst(rst),
        .req_valid(req_valid), .req_ready(req_ready), .req_we(req_we),
        .req_addr(req_addr), .req_wdata(req_wdata),
        .rsp_valid(rsp_valid), .rsp_ready(rsp_ready), .rsp_rdata(rsp_rdata),
        .busy(busy), .sram_cs(sram_cs), .sram_we(sram_we), .sram_re(sram_re),
        .sram_addr(sram_addr), .sram_din(sram_din), .sram_dout(sram_dout)
    );

    sram8t_ctrl #(.ADDR_WIDTH(4), .DATA_WIDTH(8), .RD_LAT(3)) dut3 (
        .clk(clk), .rst(rst),
        .req_valid(req_valid3), .req_ready(req_ready3), .req_we(req_we3),
        .req_addr(req_addr3), .req_wdata(req_wdata3),
        .rsp_valid(rsp_valid3), .rsp_ready(rsp_ready3), .rsp_rdata(rsp_rdata3),
        .busy(busy3), .sram_cs(sram_cs3), .sram_we(sram_we3), .sram_re(sram_re3),
        .sram_addr(sram_addr3), .sram_din(sram_din3), .sram_dout(sram_dout3)
    );

    // SRAM models: read data is valid for exactly one cycle, garbage otherwise.
    always @(posedge clk) begin
        if (sram_cs && sram_we) mem1[sram_addr] <= sram_din;
        sram_dout <= (sram_cs && sram_re) ? mem1[sram_addr] : 8'hEE;
    end

    always @(posedge clk) begin
        if (sram_cs3 && sram_we3) mem3[sram_addr3] <= sram_din3;
        p0 <= (sram_cs3 && sram_re3) ? mem3[sram_addr3] : 8'hEE;
        p1 <= p0;
        p2 <= p1;
    end
    assign sram_dout3 = p2;

    always @(negedge clk) begin
        if (sram_cs && sram_we) wr_strobes++;
        if (sram_cs) cs_strobes++;
        if (sram_we && sram_re) conflicts++;
        if (sram_we3 && sram_re3) conflicts++;
    end

    // Present a request at a negedge; returns at the negedge after acceptance.
    task automatic send(input logic we, input logic [3:0] addr, input logic [7:0] data);
        int n;
        n = 0;
        req_valid = 1'b1;
        req_we    = we;
        req_addr  = addr;
        req_wdata = data;
        while (!req_ready && n < 50) begin
            @(negedge clk);
            n++;
        end
        n_checks++;
        if (!req_ready) begin
            $display("FAIL accept_timeout: req_ready=%0b required 1", req_ready);
            n_fail++;
        end
        acc_cyc = cyc;
        if (we) exp_mem[addr] = data;
        else    exp_q.push_back(exp_mem[addr]);
        @(negedge clk);
        req_valid = 1'b0;
        req_addr  = ~addr;
        req_wdata = ~data;
    endtask

    task automatic get_rsp(input int exp_lat);
        int k;
        logic [7:0] e;
        k = 0;
        while (!rsp_valid && k < 40) begin
            @(negedge clk);
            k++;
        end
        n_checks++;
        if (!rsp_valid) begin
            $display("FAIL rsp_timeout: rsp_valid=%0b required 1", rsp_valid);
            n_fail++;
        end else begin
            n_checks++;
            if (k != exp_lat) begin
                $display("FAIL rsp_latency: got %0d cycles required %0d", k, exp_lat);
                n_fail++;
            end
            e = 8'h00;
            if (exp_q.size() > 0) e = exp_q.pop_front();
            n_checks++;
            if (rsp_rdata !== e) begin
                $display("FAIL rsp_data: got %h required %h", rsp_rdata, e);
                n_fail++;
            end
            last_rd = e;
        end
    endtask

    task automatic test_reset();
        rst = 1'b1;
        repeat (3) @(negedge clk);
        n_checks++;
        if ({req_ready, rsp_valid, rsp_rdata, busy, sram_cs, sram_we, sram_re, sram_addr, sram_din} !== 29'd0) begin
            $display("FAIL reset_outputs: got %h required 0",
                     {req_ready, rsp_valid, rsp_rdata, busy, sram_cs, sram_we, sram_re, sram_addr, sram_din});
            n_fail++;
        end
        n_checks++;
        if ({req_ready3, rsp_valid3, busy3, sram_cs3, sram_we3, sram_re3} !== 6'd0) begin
            $display("FAIL reset_outputs3: got %b required 0",
                     {req_ready3, rsp_valid3, busy3, sram_cs3, sram_we3, sram_re3});
            n_fail++;
        end
        rst = 1'b0;
        #1;
`ifdef SRAM8T_CTRL_INIT_EN
        for (int i = 0; i < 16; i++) begin
            n_checks++;
            if ({sram_cs, sram_we, sram_re, sram_addr, sram_din, req_ready, busy} !== {3'b110, 4'(i), 8'h00, 2'b01}) begin
                $display("FAIL init_cycle%0d: got cs/we/re=%b%b%b addr=%h din=%h ready=%b busy=%b required 110 %h 00 0 1",
                         i, sram_cs, sram_we, sram_re, sram_addr, sram_din, req_ready, busy, 4'(i));
                n_fail++;
            end
            @(negedge clk);
        end
        n_checks++;
        if (req_ready !== 1'b1 || busy !== 1'b0 || sram_cs !== 1'b0) begin
            $display("FAIL init_done: got ready=%b busy=%b cs=%b required 1 0 0", req_ready, busy, sram_cs);
            n_fail++;
        end
        for (int i = 0; i < 16; i++) exp_mem[i] = 8'h00;
        send(1'b0, 4'h7, 8'h00);
        get_rsp(2);
        @(negedge clk);
`else
        n_checks++;
        if (req_ready !== 1'b1 || busy !== 1'b0) begin
            $display("FAIL post_reset_idle: got ready=%b busy=%b required 1 0", req_ready, busy);
            n_fail++;
        end
        @(negedge clk);
`endif
    endtask

    task automatic test_write_read();
        int w0;
        rsp_ready = 1'b1;
        w0 = wr_strobes;
        send(1'b1, 4'h2, 8'hAA);
        n_checks++;
        if ({sram_cs, sram_we, sram_re, sram_addr, sram_din} !== {3'b110, 4'h2, 8'hAA}) begin
            $display("FAIL write_pins: got %b%b%b %h %h required 110 2 aa",
                     sram_cs, sram_we, sram_re, sram_addr, sram_din);
            n_fail++;
        end
        @(negedge clk);
        n_checks++;
        if (wr_strobes - w0 !== 1 || sram_cs !== 1'b0) begin
            $display("FAIL write_once: got %0d strobes cs=%b required 1 0", wr_strobes - w0, sram_cs);
            n_fail++;
        end
        send(1'b0, 4'h2, 8'h00);
        n_checks++;
        if ({sram_cs, sram_we, sram_re, sram_addr} !== {3'b101, 4'h2}) begin
            $display("FAIL read_pins: got %b%b%b %h required 101 2", sram_cs, sram_we, sram_re, sram_addr);
            n_fail++;
        end
        get_rsp(2);
        @(negedge clk);
        n_checks++;
        if (rsp_valid !== 1'b0 || req_ready !== 1'b1) begin
            $display("FAIL rsp_consumed: got valid=%b ready=%b required 0 1", rsp_valid, req_ready);
            n_fail++;
        end
    endtask

    task automatic test_backpressure();
        int c0;
        rsp_ready = 1'b0;
        send(1'b0, 4'h2, 8'h00);
        get_rsp(2);
        c0 = cs_strobes;
        for (int j = 0; j < 5; j++) begin
            n_checks++;
            if (rsp_valid !== 1'b1 || rsp_rdata !== last_rd || req_ready !== 1'b0) begin
                $display("FAIL hold_rsp%0d: got valid=%b data=%h ready=%b required 1 %h 0",
                         j, rsp_valid, rsp_rdata, req_ready, last_rd);
                n_fail++;
            end
            @(negedge clk);
        end
        n_checks++;
        if (cs_strobes !== c0) begin
            $display("FAIL hold_strobes: got %0d extra required 0", cs_strobes - c0);
            n_fail++;
        end
        rsp_ready = 1'b1;
        @(negedge clk);
        n_checks++;
        if (rsp_valid !== 1'b0 || req_ready !== 1'b1) begin
            $display("FAIL release_rsp: got valid=%b ready=%b required 0 1", rsp_valid, req_ready);
            n_fail++;
        end
    endtask

    task automatic test_back_to_back();
        int w0, prev;
        w0 = wr_strobes;
        prev = 0;
        for (int i = 0; i < 16; i++) begin
            send(1'b1, 4'(i), 8'(i) ^ 8'h5A);
            if (i > 0) begin
                n_checks++;
                if (acc_cyc - prev !== 2) begin
                    $display("FAIL write_rate%0d: got %0d cycles required 2", i, acc_cyc - prev);
                    n_fail++;
                end
            end
            prev = acc_cyc;
        end
        @(negedge clk);
        n_checks++;
        if (wr_strobes - w0 !== 16) begin
            $display("FAIL write_count: got %0d required 16", wr_strobes - w0);
            n_fail++;
        end
        for (int i = 0; i < 16; i++) begin
            send(1'b0, 4'(i), 8'h00);
            get_rsp(2);
        end
        @(negedge clk);
    endtask

    task automatic test_reset_abort();
        send(1'b0, 4'h5, 8'h00);
        @(negedge clk);
        rst = 1'b1;
        #1;
        n_checks++;
        if ({sram_cs, sram_we, sram_re, rsp_valid, busy, req_ready} !== 6'd0) begin
            $display("FAIL abort_outputs: got %b required 000000",
                     {sram_cs, sram_we, sram_re, rsp_valid, busy, req_ready});
            n_fail++;
        end
        repeat (2) @(negedge clk);
        rst = 1'b0;
        exp_q.delete();
        #1;
`ifdef SRAM8T_CTRL_INIT_EN
        for (int i = 0; i < 16; i++) exp_mem[i] = 8'h00;
`else
        n_checks++;
        if (req_ready !== 1'b1) begin
            $display("FAIL abort_ready: got %b required 1", req_ready);
            n_fail++;
        end
`endif
        for (int j = 0; j < 6; j++) begin
            @(negedge clk);
            n_checks++;
            if (rsp_valid !== 1'b0) begin
                $display("FAIL abort_no_rsp%0d: got %b required 0", j, rsp_valid);
                n_fail++;
            end
        end
        send(1'b0, 4'h5, 8'h00);
        get_rsp(2);
        @(negedge clk);
    endtask

    task automatic test_rd_lat3();
        int k;
        logic [7:0] e;
        rsp_ready3 = 1'b1;
        n_checks++;
        if (req_ready3 !== 1'b1) begin
            $display("FAIL lat3_ready: got %b required 1", req_ready3);
            n_fail++;
        end
        req_valid3 = 1'b1; req_we3 = 1'b1; req_addr3 = 4'h9; req_wdata3 = 8'hC3;
        @(negedge clk);
        req_valid3 = 1'b0;
        @(negedge clk);
        req_valid3 = 1'b1; req_we3 = 1'b0;
        exp_q.push_back(8'hC3);
        @(negedge clk);
        req_valid3 = 1'b0;
        k = 0;
        while (!rsp_valid3 && k < 40) begin
            @(negedge clk);
            k++;
        end
        n_checks++;
        if (k != 4) begin
            $display("FAIL lat3_latency: got %0d cycles required 4", k);
            n_fail++;
        end
        e = 8'h00;
        if (exp_q.size() > 0) e = exp_q.pop_front();
        n_checks++;
        if (rsp_rdata3 !== e) begin
            $display("FAIL lat3_data: got %h required %h", rsp_rdata3, e);
            n_fail++;
        end
        @(negedge clk);
    endtask

    task automatic test_pin_rules();
        n_checks++;
        if (conflicts !== 0) begin
            $display("FAIL we_re_conflict: got %0d cycles required 0", conflicts);
            n_fail++;
        end
    endtask

    initial begin
        test_reset();
        test_write_read();
        test_backpressure();
        test_back_to_back();
        test_reset_abort();
        test_rd_lat3();
        test_pin_rules();
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
`default_nettype wire
